// File: rtl/alu_pkg.sv
// Shared constants for the EX-stage ALU: MIPS funct codes and datapath width.
package alu_pkg;
  localparam int DATA_W = 32;
  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_SLT   = 6'd42;
  localparam logic [5:0] FN_SRL   = 6'd2;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_DIVU  = 6'd27;
  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MFLO  = 6'd18;
endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 unsigned multiply / restoring divide with HI/LO.
module muldiv_unit
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_div,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);
  logic [63:0] acc;
  logic [63:0] acc_nx;
  logic [31:0] b_r;
  logic [5:0]  cnt;
  logic        op_div;
  logic [32:0] sum;
  logic [32:0] rem_sh;
  logic [32:0] diff;

  // start is a level: high while the funct code selects MULTU/DIVU
  always_comb begin
    sum    = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? b_r : 32'd0)};
    rem_sh = acc[63:31];
    diff   = rem_sh - {1'b0, b_r};
    acc_nx = acc;
    if (op_div) begin
      if (!diff[32])
        acc_nx = {diff[31:0], acc[30:0], 1'b1};
      else
        acc_nx = {rem_sh[31:0], acc[30:0], 1'b0};
    end else begin
      acc_nx = {sum, acc[31:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      b_r    <= '0;
      cnt    <= '0;
      op_div <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else if (busy) begin
      acc <= acc_nx;
      cnt <= cnt + 6'd1;
      if (cnt == 6'd31) begin
        hi   <= acc_nx[63:32];
        lo   <= acc_nx[31:0];
        busy <= 1'b0;
        done <= 1'b1;
      end
    end else if (done) begin
      if (!start)
        done <= 1'b0;
    end else if (start) begin
      acc    <= {32'd0, a};
      b_r    <= b;
      cnt    <= '0;
      op_div <= is_div;
      busy   <= 1'b1;
    end
  end
endmodule

// File: rtl/total_alu.sv
// MIPS-style EX-stage ALU: combinational ops plus iterative MULTU/DIVU.
module total_alu
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] dataA,
  input  logic [DATA_W-1:0] dataB,
  input  logic [5:0]        Signal,
  output logic [DATA_W-1:0] Output
);
  logic              md_start;
  logic              md_div;
  logic              md_busy;
  logic              md_done;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  assign md_start = (Signal == FN_MULTU) || (Signal == FN_DIVU);
  assign md_div   = (Signal == FN_DIVU);

  muldiv_unit u_md (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start),
    .is_div (md_div),
    .a      (dataA),
    .b      (dataB),
    .busy   (md_busy),
    .done   (md_done),
    .hi     (hi),
    .lo     (lo)
  );

  always_comb begin
    Output = '0;
    unique case (Signal)
      FN_AND:  Output = dataA & dataB;
      FN_OR:   Output = dataA | dataB;
      FN_ADD:  Output = dataA + dataB;
      FN_SUB:  Output = dataA - dataB;
      FN_SLT:  Output = {31'd0, $signed(dataA) < $signed(dataB)};
      FN_SRL:  Output = dataA >> dataB[4:0];
      FN_MFHI: Output = hi;
      FN_MFLO: Output = lo;
      default: Output = '0;
    endcase
  end

  logic unused;
  assign unused = md_busy ^ md_done;
endmodule

// File: tb/tb_total_alu.sv
// Scoreboard bench for total_alu: expected results queued at drive time.
module tb_total_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [5:0]  Signal;
  logic [31:0] Output;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  total_alu dut (
    .clk    (clk),
    .reset  (reset),
    .dataA  (dataA),
    .dataB  (dataB),
    .Signal (Signal),
    .Output (Output)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input string tag, input logic [5:0] s,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    Signal = s;
    dataA  = a;
    dataB  = b;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    chk(tag_q.pop_front(), Output, exp_q.pop_front());
  endtask

  task automatic hold(input logic [5:0] s, input logic [31:0] a,
                      input logic [31:0] b, input int n);
    Signal = s;
    dataA  = a;
    dataB  = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b1;
    dataA  = '0;
    dataB  = '0;
    Signal = FN_MFHI;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    drive("rst_hi", FN_MFHI, 0, 0, 0);
    drive("rst_lo", FN_MFLO, 0, 0, 0);
    drive("and", FN_AND, 12, 10, 8);
    drive("or", FN_OR, 12, 10, 14);
    drive("add_wrap", FN_ADD, 32'hFFFFFFFF, 1, 0);
    drive("sub", FN_SUB, 5, 7, 32'hFFFFFFFE);
    drive("slt_neg", FN_SLT, 32'hFFFFFFFF, 1, 1);
    drive("slt_pos", FN_SLT, 1, 32'hFFFFFFFF, 0);
    drive("srl31", FN_SRL, 32'h80000000, 31, 1);
    drive("srl0", FN_SRL, 32'h80000000, 0, 32'h80000000);
    drive("undef", 6'd63, 32'h1234, 32'h5678, 0);

    hold(FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
    drive("multu_out", FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    drive("multu_hi", FN_MFHI, 0, 0, 32'hFFFFFFFE);
    drive("multu_lo", FN_MFLO, 0, 0, 1);

    hold(FN_DIVU, 100, 7, 35);
    drive("divu_hi", FN_MFHI, 0, 0, 2);
    drive("divu_lo", FN_MFLO, 0, 0, 14);

    hold(FN_MULTU, 3, 5, 10);
    drive("mid_run_hi", FN_MFHI, 0, 0, 2);
    hold(FN_DIVU, 99, 99, 30);
    drive("mul15_hi", FN_MFHI, 0, 0, 0);
    drive("mul15_lo", FN_MFLO, 0, 0, 15);

    hold(FN_DIVU, 100, 0, 35);
    drive("div0_hi", FN_MFHI, 0, 0, 100);
    drive("div0_lo", FN_MFLO, 0, 0, 32'hFFFFFFFF);

    hold(FN_DIVU, 100, 7, 10);
    reset  = 1'b1;
    Signal = FN_MFHI;
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive("abort_hi", FN_MFHI, 0, 0, 0);
    drive("abort_lo", FN_MFLO, 0, 0, 0);

    hold(FN_DIVU, 100, 7, 35);
    drive("redo_hi", FN_MFHI, 0, 0, 2);
    drive("redo_lo", FN_MFLO, 0, 0, 14);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
